// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture path: FSM state encoding and the
// counter saturation value derived from the counter width.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } pwm_state_t;

    // All-ones value of a counter of the given width (valid up to 32 bits).
    function automatic logic [31:0] cnt_max(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Metastability synchronizer for an asynchronous input plus a one-cycle history
// flop, producing the clean level and single-cycle rise/fall strobes.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~prev_reg;
    assign fall = ~s & prev_reg;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time (rise to fall) of an external
// PWM signal in clk cycles; a line with no edges is reported via timeout.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int COUNTER_WIDTH = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     pwm_in,
    output logic [COUNTER_WIDTH-1:0] period_out,
    output logic [COUNTER_WIDTH-1:0] duty_out,
    output logic                     valid,
    output logic                     timeout,
    output logic                     stuck_level
);

    localparam logic [COUNTER_WIDTH-1:0] MAX = COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));
    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    logic s, rise, fall;

    pwm_state_t               state_reg;
    logic [COUNTER_WIDTH-1:0] cnt_reg;
    logic [COUNTER_WIDTH-1:0] duty_lat_reg;
    logic [COUNTER_WIDTH-1:0] period_reg;
    logic [COUNTER_WIDTH-1:0] duty_reg;
    logic                     valid_reg;
    logic                     timeout_reg;
    logic                     stuck_reg;

    logic [COUNTER_WIDTH-1:0] cnt_next;
    logic                     expired;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pwm_in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    // Saturating increment; an edge landing on MAX still takes the normal path.
    always_comb begin
        cnt_next = (cnt_reg == MAX) ? MAX : cnt_reg + ONE;
        expired  = (cnt_reg == MAX) && !rise && !fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            duty_lat_reg <= '0;
            period_reg   <= '0;
            duty_reg     <= '0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            stuck_reg    <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
            if (!enable) begin
                state_reg    <= ST_IDLE;
                cnt_reg      <= '0;
                duty_lat_reg <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        // Partial first cycle is discarded; measurement starts at a rise.
                        if (rise) begin
                            cnt_reg   <= ONE;
                            state_reg <= ST_HIGH;
                        end else if (expired) begin
                            timeout_reg <= 1'b1;
                            period_reg  <= '0;
                            duty_reg    <= '0;
                            stuck_reg   <= s;
                            cnt_reg     <= '0;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                    ST_HIGH: begin
                        if (fall) begin
                            duty_lat_reg <= cnt_reg;
                            cnt_reg      <= cnt_next;
                            state_reg    <= ST_LOW;
                        end else if (expired) begin
                            timeout_reg <= 1'b1;
                            period_reg  <= '0;
                            duty_reg    <= '0;
                            stuck_reg   <= s;
                            cnt_reg     <= '0;
                            state_reg   <= ST_WAIT_RISE;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                    ST_LOW: begin
                        if (rise) begin
                            period_reg <= cnt_reg;
                            duty_reg   <= duty_lat_reg;
                            valid_reg  <= 1'b1;
                            cnt_reg    <= ONE;
                            state_reg  <= ST_HIGH;
                        end else if (expired) begin
                            timeout_reg <= 1'b1;
                            period_reg  <= '0;
                            duty_reg    <= '0;
                            stuck_reg   <= s;
                            cnt_reg     <= '0;
                            state_reg   <= ST_WAIT_RISE;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign period_out  = period_reg;
    assign duty_out    = duty_reg;
    assign valid       = valid_reg;
    assign timeout     = timeout_reg;
    assign stuck_level = stuck_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench: the stimulus side predicts each valid/timeout from the
// waveform it drives; an independent monitor pops and compares on every pulse.
module tb_pwm_capture;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         enable = 1'b0;
    logic         pwm_in = 1'b0;
    logic [W-1:0] period_out;
    logic [W-1:0] duty_out;
    logic         valid;
    logic         timeout;
    logic         stuck_level;

    pwm_capture #(
        .COUNTER_WIDTH(W),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .duty_out   (duty_out),
        .valid      (valid),
        .timeout    (timeout),
        .stuck_level(stuck_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_to;
        int period;
        int duty;
        bit stuck;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: cycle times of rises/falls of the waveform being driven.
    bit armed     = 1'b0;
    bit have_rise = 1'b0;
    bit level     = 1'b0;
    int last_rise = 0;
    int last_fall = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_timeouts(input int n, input bit lv);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.is_to  = 1'b1;
            e.period = 0;
            e.duty   = 0;
            e.stuck  = lv;
            e.cyc    = -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input bit lv);
        exp_t e;
        @(posedge clk);
        #1;
        pwm_in = lv;
        if (armed && lv != level) begin
            if (lv) begin
                if (have_rise) begin
                    e.is_to  = 1'b0;
                    e.period = cyc - last_rise;
                    e.duty   = last_fall - last_rise;
                    e.stuck  = 1'b0;
                    e.cyc    = cyc + LAT;
                    exp_q.push_back(e);
                end
                last_rise = cyc;
                have_rise = 1'b1;
            end else begin
                last_fall = cyc;
            end
        end
        level = lv;
    endtask

    task automatic seg(input bit lv, input int n);
        for (int i = 0; i < n; i++) step(lv);
    endtask

    task automatic blocks(input int p, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            seg(1'b1, d);
            seg(1'b0, p - d);
        end
    endtask

    task automatic set_en(input bit v);
        enable = v;
        armed  = v;
        if (!v) have_rise = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, period_out, 0);
        check({tag, "_duty"}, duty_out, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_stuck"}, stuck_level, 0);
    endtask

    // Monitor: consumes one expectation per output pulse.
    bit   prev_pulse = 1'b0;
    int   last_to    = -1;
    exp_t got;
    always @(negedge clk) begin
        if (!enable || !rst_n) last_to <= -1;
        if (valid || timeout) begin
            check("pulse_exclusive", int'(valid && timeout), 0);
            check("pulse_width", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b timeout=%0b period=%0d duty=%0d, none expected (cycle %0d)",
                         valid, timeout, period_out, duty_out, cyc);
            end else begin
                got = exp_q.pop_front();
                check("pulse_kind_timeout", int'(timeout), int'(got.is_to));
                check("period_out", period_out, got.period);
                check("duty_out", duty_out, got.duty);
                if (got.is_to) begin
                    check("stuck_level", stuck_level, got.stuck);
                    if (last_to >= 0) begin
                        checks++;
                        if (cyc - last_to < 255 || cyc - last_to > 256) begin
                            errors++;
                            $display("FAIL timeout_spacing: got %0d cycles expected 255..256", cyc - last_to);
                        end
                    end
                    last_to <= cyc;
                end else begin
                    check("valid_cycle", cyc, got.cyc);
                end
            end
        end
        prev_pulse <= valid || timeout;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit with %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        rst_n = 1'b1;
        seg(1'b0, 2);
        set_en(1'b1);
        seg(1'b0, 4);

        // Nominal 10/3, duty change to 10/7, then the narrowest 2/1 waveform.
        blocks(10, 3, 6);
        blocks(10, 7, 4);
        blocks(2, 1, 8);
        seg(1'b0, 4);

        // Line stuck low, then stuck high: three timeouts each, no valid.
        set_en(1'b0);
        seg(1'b0, 4);
        set_en(1'b1);
        push_timeouts(3, 1'b0);
        seg(1'b0, 900);
        set_en(1'b0);
        seg(1'b1, 4);
        set_en(1'b1);
        push_timeouts(3, 1'b1);
        seg(1'b1, 900);
        set_en(1'b0);
        seg(1'b0, 4);
        set_en(1'b1);
        seg(1'b0, 3);

        // Enable dropped for five cycles while the FSM is in HIGH.
        blocks(10, 3, 3);
        seg(1'b1, 3);
        seg(1'b0, 1);
        set_en(1'b0);
        seg(1'b0, 3);
        check("hold_period", period_out, 10);
        check("hold_duty", duty_out, 3);
        seg(1'b0, 2);
        set_en(1'b1);
        seg(1'b0, 1);
        blocks(10, 3, 3);

        // Asynchronous reset in the middle of the low phase.
        seg(1'b1, 3);
        seg(1'b0, 3);
        check("pre_reset_period", period_out, 10);
        #1;
        rst_n     = 1'b0;
        have_rise = 1'b0;
        #1;
        check_zero("async_reset");
        seg(1'b0, 2);
        #2;
        rst_n = 1'b1;
        seg(1'b0, 2);
        blocks(10, 4, 3);

        // Randomized periods and duties.
        for (int i = 0; i < 30; i++) begin
            int p;
            int d;
            p = int'($urandom_range(40, 2));
            d = int'($urandom_range(p - 1, 1));
            blocks(p, d, 1);
        end

        // Period of exactly MAX: the closing rise coincides with cnt==MAX.
        blocks(255, 100, 2);
        seg(1'b1, 3);
        seg(1'b0, 10);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
